// File: rtl/nios2_jtag_sysclk_bridge.sv
// nios2_jtag_sysclk_bridge
//   System-clock side of the Nios II JTAG debug bridge. Synchronises the
//   virtual-JTAG update-DR / update-IR strobes, turns each rising edge into
//   an event {kind, ir, data}, presents it on a valid/ready port and decodes
//   consumed DR events into one-hot take_action / take_no_action pulses plus
//   a registered jdo word.
//
//   Build option NIOS2_JTAG_BRIDGE_QUEUE_EN:
//     defined   - QUEUE_DEPTH-entry FIFO; evt_valid holds until handshaken.
//     undefined - single register stage; each event is valid for one cycle
//                 and consumed unconditionally (evt_ready ignored).
//
// Ports
//   clk, reset        system clock, asynchronous active-high reset
//   ir_in, sr         virtual IR and shift register (TCK domain, quasi-static)
//   vs_udr, vs_uir    update-DR / update-IR levels (asynchronous)
//   evt_ready         consumer accepts head event
//   clear_err         clears sticky error flags
//   evt_valid/kind/ir/data  head event (kind 0 = DR, 1 = IR)
//   jdo               data of last consumed DR event
//   take_action/take_no_action  one-hot pulses indexed by event IR
//   err_overflow      sticky: event dropped on full queue
//   err_collision     sticky: DR and IR edges in the same cycle
module nios2_jtag_sysclk_bridge #(
    parameter int IR_WIDTH    = 2,
    parameter int DR_WIDTH    = 38,
    parameter int ACT_BIT     = 35,
    parameter int SYNC_STAGES = 2,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [IR_WIDTH-1:0]        ir_in,
    input  logic [DR_WIDTH-1:0]        sr,
    input  logic                       vs_udr,
    input  logic                       vs_uir,
    input  logic                       evt_ready,
    input  logic                       clear_err,
    output logic                       evt_valid,
    output logic                       evt_kind,
    output logic [IR_WIDTH-1:0]        evt_ir,
    output logic [DR_WIDTH-1:0]        evt_data,
    output logic [DR_WIDTH-1:0]        jdo,
    output logic [(1<<IR_WIDTH)-1:0]   take_action,
    output logic [(1<<IR_WIDTH)-1:0]   take_no_action,
    output logic                       err_overflow,
    output logic                       err_collision
);
    localparam int N          = 1 << IR_WIDTH;
    localparam int ARM_CYCLES = SYNC_STAGES + 1;
    localparam int ARM_W      = $clog2(ARM_CYCLES + 1);

    // ---------------- strobe synchronisers and edge detect ----------------
    logic [SYNC_STAGES-1:0] r_udr_sync, r_uir_sync;
    logic                   r_udr_prev, r_uir_prev;
    logic [ARM_W-1:0]       r_arm_cnt;
    logic                   w_armed, w_dr_edge, w_ir_edge, w_new_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_udr_sync <= '0;
            r_uir_sync <= '0;
            r_udr_prev <= 1'b0;
            r_uir_prev <= 1'b0;
            r_arm_cnt  <= '0;
        end else begin
            r_udr_sync <= {r_udr_sync[SYNC_STAGES-2:0], vs_udr};
            r_uir_sync <= {r_uir_sync[SYNC_STAGES-2:0], vs_uir};
            r_udr_prev <= r_udr_sync[SYNC_STAGES-1];
            r_uir_prev <= r_uir_sync[SYNC_STAGES-1];
            if (!w_armed)
                r_arm_cnt <= r_arm_cnt + 1'b1;
        end
    end

    // Edges stay masked until the chain and s_prev have both filled, so a
    // strobe already high when reset lifts looks like a steady level.
    assign w_armed     = (r_arm_cnt == ARM_W'(ARM_CYCLES));
    assign w_dr_edge   = w_armed & r_udr_sync[SYNC_STAGES-1] & ~r_udr_prev;
    assign w_ir_edge   = w_armed & r_uir_sync[SYNC_STAGES-1] & ~r_uir_prev;
    assign w_new_valid = w_dr_edge | w_ir_edge;

    // DR wins a same-cycle collision; IR events carry zero data.
    logic                w_new_kind;
    logic [DR_WIDTH-1:0] w_new_data;
    assign w_new_kind = ~w_dr_edge;
    assign w_new_data = w_dr_edge ? sr : '0;

    // ---------------- event storage ----------------
    logic                r_evt_valid;
    logic                w_pop, w_overflow_set;
    logic                w_head_kind;
    logic [IR_WIDTH-1:0] w_head_ir;
    logic [DR_WIDTH-1:0] w_head_data;

`ifdef NIOS2_JTAG_BRIDGE_QUEUE_EN
    localparam int PTR_W = $clog2(QUEUE_DEPTH);

    logic                r_q_kind [QUEUE_DEPTH];
    logic [IR_WIDTH-1:0] r_q_ir   [QUEUE_DEPTH];
    logic [DR_WIDTH-1:0] r_q_data [QUEUE_DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr, r_rd_ptr;
    logic [PTR_W:0]      r_count, w_count_next;
    logic                w_full, w_push;

    assign w_pop          = r_evt_valid & evt_ready;
    assign w_full         = (r_count == (PTR_W+1)'(QUEUE_DEPTH));
    // A pop in the same cycle frees the slot, so full+pop+push is legal.
    assign w_push         = w_new_valid & (~w_full | w_pop);
    assign w_overflow_set = w_new_valid & ~w_push;
    assign w_count_next   = r_count + {{PTR_W{1'b0}}, w_push}
                                    - {{PTR_W{1'b0}}, w_pop};

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_kind[r_wr_ptr] <= w_new_kind;
            r_q_ir[r_wr_ptr]   <= ir_in;
            r_q_data[r_wr_ptr] <= w_new_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_evt_valid <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count     <= w_count_next;
            r_evt_valid <= (w_count_next != '0);
        end
    end

    // Head fields are forced to zero when empty so stale entries never show.
    assign w_head_kind = r_evt_valid & r_q_kind[r_rd_ptr];
    assign w_head_ir   = r_evt_valid ? r_q_ir[r_rd_ptr]   : '0;
    assign w_head_data = r_evt_valid ? r_q_data[r_rd_ptr] : '0;
`else
    logic                r_evt_kind;
    logic [IR_WIDTH-1:0] r_evt_ir;
    logic [DR_WIDTH-1:0] r_evt_data;
    logic                w_unused_cfg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_evt_valid <= 1'b0;
            r_evt_kind  <= 1'b0;
            r_evt_ir    <= '0;
            r_evt_data  <= '0;
        end else begin
            r_evt_valid <= w_new_valid;
            r_evt_kind  <= w_new_valid & w_new_kind;
            r_evt_ir    <= w_new_valid ? ir_in : '0;
            r_evt_data  <= w_new_data;
        end
    end

    // Legacy strobe behaviour: the event is taken the cycle it is shown.
    assign w_pop          = r_evt_valid;
    assign w_overflow_set = 1'b0;
    assign w_head_kind    = r_evt_kind;
    assign w_head_ir      = r_evt_ir;
    assign w_head_data    = r_evt_data;
    assign w_unused_cfg   = evt_ready | (QUEUE_DEPTH < 2);
`endif

    assign evt_valid = r_evt_valid;
    assign evt_kind  = w_head_kind;
    assign evt_ir    = w_head_ir;
    assign evt_data  = w_head_data;

    // ---------------- consume decode ----------------
    logic [N-1:0] w_onehot;
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_onehot
            assign w_onehot[gi] = (w_head_ir == IR_WIDTH'(gi));
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            jdo            <= '0;
            take_action    <= '0;
            take_no_action <= '0;
            err_overflow   <= 1'b0;
            err_collision  <= 1'b0;
        end else begin
            take_action    <= '0;
            take_no_action <= '0;
            if (w_pop && !w_head_kind) begin
                jdo <= w_head_data;
                if (w_head_data[ACT_BIT])
                    take_action <= w_onehot;
                else
                    take_no_action <= w_onehot;
            end
            // A new error in the clearing cycle keeps the flag set.
            if (w_dr_edge && w_ir_edge) err_collision <= 1'b1;
            else if (clear_err)         err_collision <= 1'b0;
            if (w_overflow_set)         err_overflow  <= 1'b1;
            else if (clear_err)         err_overflow  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_nios2_jtag_sysclk_bridge.sv
module tb_nios2_jtag_sysclk_bridge;
    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  ir_in;
    logic [37:0] sr;
    logic        vs_udr, vs_uir, evt_ready, clear_err;
    logic        evt_valid, evt_kind;
    logic [1:0]  evt_ir;
    logic [37:0] evt_data, jdo;
    logic [3:0]  take_action, take_no_action;
    logic        err_overflow, err_collision;

    always #5 clk = ~clk;

    nios2_jtag_sysclk_bridge #(
        .IR_WIDTH(2), .DR_WIDTH(38), .ACT_BIT(35), .SYNC_STAGES(2), .QUEUE_DEPTH(4)
    ) dut (
        .clk(clk), .reset(reset), .ir_in(ir_in), .sr(sr),
        .vs_udr(vs_udr), .vs_uir(vs_uir), .evt_ready(evt_ready), .clear_err(clear_err),
        .evt_valid(evt_valid), .evt_kind(evt_kind), .evt_ir(evt_ir), .evt_data(evt_data),
        .jdo(jdo), .take_action(take_action), .take_no_action(take_no_action),
        .err_overflow(err_overflow), .err_collision(err_collision)
    );

    typedef struct {
        logic        kind;
        logic [1:0]  ir;
        logic [37:0] data;
    } ev_t;

    ev_t         mq[$];        // events expected, in consumption order
    logic [37:0] exp_jdo;
    int          n_checks = 0;
    int          n_fail   = 0;
    bit          rand_rdy = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: decide from pre-edge view whether the head is consumed,
    // compare it with the model, then check jdo and pulses after the edge.
    task automatic cycle();
        bit         cons;
        logic [3:0] eta, etna;
        ev_t        e;
        if (rand_rdy) evt_ready = 1'($urandom_range(0, 1));
        #1;
        eta  = 4'b0;
        etna = 4'b0;
`ifdef NIOS2_JTAG_BRIDGE_QUEUE_EN
        cons = (evt_valid === 1'b1) && (evt_ready === 1'b1) && !reset;
`else
        cons = (evt_valid === 1'b1) && !reset;
`endif
        if (cons) begin
            check("sb_event_expected", 64'(mq.size() != 0), 64'd1);
            if (mq.size() != 0) begin
                e = mq.pop_front();
                $display("evt consumed kind=%0d ir=%0d data=%0h", evt_kind, evt_ir, evt_data);
                check("sb_kind", 64'(evt_kind), 64'(e.kind));
                check("sb_ir",   64'(evt_ir),   64'(e.ir));
                check("sb_data", 64'(evt_data), 64'(e.data));
                if (!e.kind) begin
                    exp_jdo = e.data;
                    if (e.data[35]) eta  = 4'b1 << e.ir;
                    else            etna = 4'b1 << e.ir;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        check("jdo",            64'(jdo),            64'(exp_jdo));
        check("take_action",    64'(take_action),    64'(eta));
        check("take_no_action", 64'(take_no_action), 64'(etna));
    endtask

    // Raise a strobe for two cycles; data held until the event is captured.
    task automatic pulse(input bit is_dr, input bit is_ir, input logic [1:0] ir,
                         input logic [37:0] data, input bit stored);
        ev_t e;
        ir_in = ir; sr = data; vs_udr = is_dr; vs_uir = is_ir;
        if (stored) begin
            e.kind = !is_dr;
            e.ir   = ir;
            e.data = is_dr ? data : 38'h0;
            mq.push_back(e);
        end
        cycle(); cycle();
        vs_udr = 1'b0; vs_uir = 1'b0;
        cycle(); cycle();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        mq.delete();
        exp_jdo = '0;
        cycle(); cycle();
        check("rst_valid", 64'(evt_valid), 64'd0);
        check("rst_data",  64'(evt_data),  64'd0);
        check("rst_ovf",   64'(err_overflow), 64'd0);
        check("rst_col",   64'(err_collision), 64'd0);
        reset = 1'b0;
    endtask

    initial begin
        ir_in = '0; sr = '0; vs_udr = 1'b1; vs_uir = 1'b0;
        evt_ready = 1'b0; clear_err = 1'b0;

        // Strobe held high through reset must not produce an event.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cycle();
            check("arm_no_evt", 64'(evt_valid), 64'd0);
        end
        vs_udr = 1'b0;
        cycle(); cycle(); cycle();

        // Latency and take_action decode.
        begin
            ev_t e;
            evt_ready = 1'b1;
            ir_in = 2'd2; sr = 38'h08_0000_1234; vs_udr = 1'b1;
            e.kind = 1'b0; e.ir = 2'd2; e.data = 38'h08_0000_1234;
            mq.push_back(e);
            cycle(); cycle();
            check("lat_not_yet", 64'(evt_valid), 64'd0);
            vs_udr = 1'b0;
            cycle();
            check("lat_valid", 64'(evt_valid), 64'd1);
            check("lat_data",  64'(evt_data),  64'h08_0000_1234);
            cycle();
            check("act_jdo",   64'(jdo), 64'h08_0000_1234);
            check("act_pulse", 64'(take_action), 64'h4);
            check("act_empty", 64'(evt_valid), 64'd0);
            cycle();
            check("act_one_cycle", 64'(take_action), 64'd0);
        end

        // take_no_action decode.
        pulse(1, 0, 2'd0, 38'h00_0000_00AB, 1);
        check("noact_pulse", 64'(take_no_action), 64'h1);
        check("noact_ta",    64'(take_action),    64'd0);
        check("noact_jdo",   64'(jdo), 64'hAB);

        // Collision: one DR event, flag set, cleared, then clear vs new error.
        ir_in = 2'd1; sr = 38'h12_3456_789A; vs_udr = 1'b1; vs_uir = 1'b1;
        begin
            ev_t e;
            e.kind = 1'b0; e.ir = 2'd1; e.data = 38'h12_3456_789A;
            mq.push_back(e);
        end
        cycle(); cycle();
        check("col_before", 64'(err_collision), 64'd0);
        vs_udr = 1'b0; vs_uir = 1'b0;
        cycle();
        check("col_set", 64'(err_collision), 64'd1);
        cycle(); cycle();
        clear_err = 1'b1; cycle(); clear_err = 1'b0;
        check("col_clear", 64'(err_collision), 64'd0);
        ir_in = 2'd3; sr = 38'h01_0000_0001; vs_udr = 1'b1; vs_uir = 1'b1;
        begin
            ev_t e;
            e.kind = 1'b0; e.ir = 2'd3; e.data = 38'h01_0000_0001;
            mq.push_back(e);
        end
        cycle(); cycle();
        vs_udr = 1'b0; vs_uir = 1'b0; clear_err = 1'b1;
        cycle();
        clear_err = 1'b0;
        check("col_sticky_vs_clear", 64'(err_collision), 64'd1);
        cycle(); cycle();
        clear_err = 1'b1; cycle(); clear_err = 1'b0;
        check("col_clear2", 64'(err_collision), 64'd0);

        // evt_ready low: queue holds the event, legacy mode shows it once.
        evt_ready = 1'b0;
        begin
            ev_t e;
            ir_in = 2'd3; sr = 38'h08_0000_0055; vs_udr = 1'b1;
            e.kind = 1'b0; e.ir = 2'd3; e.data = 38'h08_0000_0055;
            mq.push_back(e);
            cycle(); cycle();
            vs_udr = 1'b0;
            cycle();
            check("hold_valid", 64'(evt_valid), 64'd1);
            cycle();
`ifdef NIOS2_JTAG_BRIDGE_QUEUE_EN
            check("hold_still_valid", 64'(evt_valid), 64'd1);
            evt_ready = 1'b1;
            cycle();
            check("hold_drained_pulse", 64'(take_action), 64'h8);
            evt_ready = 1'b0;
`else
            check("legacy_one_cycle", 64'(evt_valid), 64'd0);
            check("legacy_pulse", 64'(take_action), 64'h8);
`endif
            cycle();
        end

`ifdef NIOS2_JTAG_BRIDGE_QUEUE_EN
        // Overflow: five events into a four-deep queue, then drain in order.
        for (int i = 1; i <= 5; i++)
            pulse(1, 0, 2'(i), 38'(i), i <= 4);
        check("ovf_set",   64'(err_overflow), 64'd1);
        check("ovf_head",  64'(evt_data), 64'd1);
        evt_ready = 1'b1;
        for (int i = 0; i < 6; i++) cycle();
        check("ovf_drained", 64'(evt_valid), 64'd0);
        check("ovf_model_empty", 64'(mq.size()), 64'd0);
        clear_err = 1'b1; cycle(); clear_err = 1'b0;
        check("ovf_clear", 64'(err_overflow), 64'd0);
`else
        check("legacy_no_ovf", 64'(err_overflow), 64'd0);
`endif

        // Randomised traffic with random backpressure.
        rand_rdy = 1;
        for (int op = 0; op < 150; op++) begin
            int          kind_sel;
            logic [37:0] d;
            kind_sel = $urandom_range(0, 3);
            d = {6'($urandom), 32'($urandom)};
            if (kind_sel == 0 || mq.size() >= 4) cycle();
            else if (kind_sel == 2) pulse(0, 1, 2'($urandom_range(0, 3)), d, 1);
            else pulse(1, 0, 2'($urandom_range(0, 3)), d, 1);
        end
        rand_rdy = 0;
        evt_ready = 1'b1;
        for (int i = 0; i < 12; i++) cycle();
        check("rand_all_consumed", 64'(mq.size()), 64'd0);
        check("rand_idle", 64'(evt_valid), 64'd0);
        check("rand_no_ovf", 64'(err_overflow), 64'd0);

        // Reset mid-operation discards pending events.
        evt_ready = 1'b0;
        pulse(1, 0, 2'd1, 38'h08_0000_0777, 1);
        do_reset();
        check("midrst_jdo", 64'(jdo), 64'd0);
        for (int i = 0; i < 4; i++) cycle();
        check("midrst_idle", 64'(evt_valid), 64'd0);
        evt_ready = 1'b1;
        pulse(1, 0, 2'd2, 38'h08_0000_0999, 1);
        check("after_rst_pulse", 64'(take_action), 64'h4);
        cycle();
        check("after_rst_empty", 64'(mq.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
